// File: rtl/wpu_stream_if.sv
// Stream bundle between the weight loader and the weight preprocessing unit.
// Loader side drives in_*, consumes out_*; the unit is the slave.
interface wpu_stream_if #(
  parameter int WEIGHT_W = 8,
  parameter int ROWS     = 8,
  parameter int COLS     = 8
);
  localparam int H      = WEIGHT_W / 2;
  localparam int RB     = $clog2(ROWS);
  localparam int ADDR_W = $clog2(ROWS * COLS);
  localparam int CCW    = $clog2(ROWS + 1);

  logic                in_valid;
  logic                in_ready;
  logic [WEIGHT_W-1:0] in_weight;
  logic [ADDR_W-1:0]   in_addr;

  logic                out_valid;
  logic                out_ready;
  logic [H:0]          out_reduced;
  logic [H-2:0]        out_comp;
  logic [RB-1:0]       out_comp_row;
  logic                out_comp_valid;
  logic [ADDR_W-1:0]   out_addr;
  logic                out_col_last;
  logic [CCW-1:0]      out_col_comp_cnt;

  modport slave (
    input  in_valid, in_weight, in_addr, out_ready,
    output in_ready, out_valid, out_reduced, out_comp,
    output out_comp_row, out_comp_valid, out_addr,
    output out_col_last, out_col_comp_cnt
  );

  modport master (
    output in_valid, in_weight, in_addr, out_ready,
    input  in_ready, out_valid, out_reduced, out_comp,
    input  out_comp_row, out_comp_valid, out_addr,
    input  out_col_last, out_col_comp_cnt
  );
endinterface

// File: rtl/wpu_stream.sv
// Weight preprocessing unit: splits weights into a reduced weight plus an
// optional compensation term, tracking per-column and per-frame counts.
module wpu_stream #(
  parameter int WEIGHT_W = 8,
  parameter int ROWS     = 8,
  parameter int COLS     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  wpu_stream_if.slave                   bus,
  output logic [$clog2(ROWS*COLS+1)-1:0] comp_total,
  output logic                          busy,
  output logic                          frame_done
);
  localparam int H      = WEIGHT_W / 2;
  localparam int RB     = $clog2(ROWS);
  localparam int N      = ROWS * COLS;
  localparam int ADDR_W = $clog2(N);
  localparam int CCW    = $clog2(ROWS + 1);
  localparam int CTW    = $clog2(N + 1);
  localparam logic [CTW-1:0] LAST = CTW'(N - 1);
  localparam logic [RB-1:0]  LROW = RB'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CTW-1:0]    r_in_cnt;
  logic [CTW-1:0]    r_out_cnt;
  logic [CTW-1:0]    r_comp_total;
  logic [CCW-1:0]    r_col_cnt;
  logic              r_done;
  logic              r_out_valid;
  logic [H:0]        r_red;
  logic [H-2:0]      r_comp;
  logic [RB-1:0]     r_row;
  logic              r_cv;
  logic [ADDR_W-1:0] r_addr;
  logic              r_last;
  logic [CCW-1:0]    r_ccnt;

  logic [H-1:0] w_hi;
  logic         w_msr;
  logic         w_nm;
  logic         w_islast;
  logic         w_in_ready;
  logic         w_acc;
  logic         w_hs;
  logic         w_clr;
  logic         w_done;

  assign w_hi       = bus.in_weight[WEIGHT_W-1:H];
  assign w_msr      = (&w_hi) | ~(|w_hi);
  assign w_nm       = ~w_msr;
  assign w_islast   = (bus.in_addr[RB-1:0] == LROW);
  assign w_in_ready = (r_state == S_LOAD) & (~r_out_valid | bus.out_ready);
  assign w_acc      = bus.in_valid & w_in_ready;
  assign w_hs       = r_out_valid & bus.out_ready;
  assign w_clr      = (r_state == S_IDLE) & start;
  assign w_done     = (r_state == S_DRAIN) & w_hs & (r_out_cnt == LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  if (w_acc && r_in_cnt == LAST) w_next = S_DRAIN;
      S_DRAIN: if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_comp_total <= '0;
      r_col_cnt    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      if (w_clr) begin
        r_in_cnt     <= '0;
        r_out_cnt    <= '0;
        r_comp_total <= '0;
        r_col_cnt    <= '0;
      end else begin
        if (w_acc) r_in_cnt <= r_in_cnt + CTW'(1);
        if (w_hs)  r_out_cnt <= r_out_cnt + CTW'(1);
        if (w_acc && w_nm) r_comp_total <= r_comp_total + CTW'(1);
        if (w_acc) begin
          if (w_islast) r_col_cnt <= '0;
          else          r_col_cnt <= r_col_cnt + CCW'(w_nm);
        end
      end
    end
  end

  // Single output register: a new beat loads only when the slot is free or
  // draining this cycle, so fields hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_red       <= '0;
      r_comp      <= '0;
      r_row       <= '0;
      r_cv        <= 1'b0;
      r_addr      <= '0;
      r_last      <= 1'b0;
      r_ccnt      <= '0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_red  <= w_msr ? {1'b0, bus.in_weight[H:1]} : {1'b1, w_hi};
      r_comp <= w_msr ? '0 : bus.in_weight[H-1:1];
      r_row  <= w_msr ? '0 : bus.in_addr[RB-1:0];
      r_cv   <= w_nm;
      r_addr <= bus.in_addr;
      r_last <= w_islast;
      r_ccnt <= w_islast ? r_col_cnt + CCW'(w_nm) : '0;
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready         = w_in_ready;
  assign bus.out_valid        = r_out_valid;
  assign bus.out_reduced      = r_red;
  assign bus.out_comp         = r_comp;
  assign bus.out_comp_row     = r_row;
  assign bus.out_comp_valid   = r_cv;
  assign bus.out_addr         = r_addr;
  assign bus.out_col_last     = r_last;
  assign bus.out_col_comp_cnt = r_ccnt;
  assign comp_total           = r_comp_total;
  assign busy                 = (r_state != S_IDLE);
  assign frame_done           = r_done;
endmodule

// File: tb/tb_wpu_stream.sv
// Testbench for wpu_stream: directed and randomized frames checked
// against a queue-based reference model.
module tb_wpu_stream;
  localparam int W    = 8;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int H    = W / 2;
  localparam int RB   = 3;
  localparam int N    = ROWS * COLS;
  localparam int A    = 6;
  localparam int CCW  = 4;
  localparam int CTW  = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [CTW-1:0] comp_total;
  logic busy;
  logic frame_done;

  wpu_stream_if #(.WEIGHT_W(W), .ROWS(ROWS), .COLS(COLS)) bus ();

  wpu_stream #(.WEIGHT_W(W), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .comp_total (comp_total),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [H:0]     red;
    logic [H-2:0]   comp;
    logic [RB-1:0]  row;
    logic           cv;
    logic [A-1:0]   addr;
    logic           last;
    logic [CCW-1:0] ccnt;
  } beat_t;

  beat_t q[$];
  int tests = 0;
  int fails = 0;
  int m_col = 0;
  int m_total = 0;
  int nbeats = 0;
  int fd_cnt = 0;

  function automatic bit is_msr(input int wi);
    int hi;
    hi = (wi >> H) & ((1 << H) - 1);
    return (hi == 0) || (hi == (1 << H) - 1);
  endfunction

  function automatic beat_t model(input logic [W-1:0] w, input logic [A-1:0] a);
    beat_t b;
    int wi, ai, row, nm;
    wi = int'(w);
    ai = int'(a);
    row = ai % ROWS;
    nm = is_msr(wi) ? 0 : 1;
    if (nm == 0) begin
      b.red  = (H+1)'((wi >> 1) & ((1 << H) - 1));
      b.comp = '0;
      b.row  = '0;
    end else begin
      b.red  = (H+1)'((1 << H) | ((wi >> H) & ((1 << H) - 1)));
      b.comp = (H-1)'((wi >> 1) & ((1 << (H - 1)) - 1));
      b.row  = RB'(row);
    end
    b.cv   = nm[0];
    b.addr = a;
    b.last = (row == ROWS - 1);
    if (row == ROWS - 1) begin
      b.ccnt = CCW'(m_col + nm);
      m_col = 0;
    end else begin
      b.ccnt = '0;
      m_col = m_col + nm;
    end
    m_total = m_total + nm;
    return b;
  endfunction

  task automatic cycle(input logic v, input logic [W-1:0] w,
                       input logic [A-1:0] a, input logic rdy,
                       input logic st, output logic acc);
    beat_t act;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_weight = w;
    bus.in_addr = a;
    bus.out_ready = rdy;
    start = st;
    #1;
    if (frame_done) fd_cnt++;
    acc = v && bus.in_ready;
    if (bus.out_valid && rdy) begin
      act.red  = bus.out_reduced;
      act.comp = bus.out_comp;
      act.row  = bus.out_comp_row;
      act.cv   = bus.out_comp_valid;
      act.addr = bus.out_addr;
      act.last = bus.out_col_last;
      act.ccnt = bus.out_col_comp_cnt;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL beat_extra: got %h, expected no beat", act);
      end else begin
        if (act !== q[0]) begin
          fails++;
          $display("FAIL beat: got %h, expected %h", act, q[0]);
        end
        void'(q.pop_front());
      end
      nbeats++;
    end
    if (acc) q.push_back(model(w, a));
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_col = 0;
    m_total = 0;
  endtask

  task automatic do_start();
    logic acc;
    cycle(1'b0, '0, '0, 1'b1, 1'b1, acc);
    #1 start = 1'b0;
    m_col = 0;
    m_total = 0;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 10 && (q.size() != 0 || bus.out_valid); i++)
      cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    tests++;
    if (q.size() != 0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain: got q=%0d ov=%b, expected 0 0", q.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset();
    logic [45:0] snap;
    bus.in_valid = 1'b0;
    bus.in_weight = '0;
    bus.in_addr = '0;
    bus.out_ready = 1'b0;
    #1;
    snap = {bus.out_valid, bus.out_reduced, bus.out_comp, bus.out_comp_row,
            bus.out_comp_valid, bus.out_addr, bus.out_col_last,
            bus.out_col_comp_cnt, comp_total, busy, frame_done, bus.in_ready};
    tests++;
    if (snap !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, expected 0", snap);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_ready: got busy=%b rdy=%b, expected 0 0", busy, bus.in_ready);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_classify();
    logic acc;
    do_reset();
    do_start();
    tests++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_entry: got busy=%b rdy=%b, expected 1 1", busy, bus.in_ready);
    end
    cycle(1'b1, 8'h35, 6'd5, 1'b1, 1'b0, acc);
    #1;
    tests++;
    if ({bus.out_valid, bus.out_reduced, bus.out_comp, bus.out_comp_row,
         bus.out_comp_valid, bus.out_addr} !== {1'b1, 5'h13, 3'd2, 3'd5, 1'b1, 6'd5}) begin
      fails++;
      $display("FAIL cls_35: got red=%h comp=%h row=%h cv=%b addr=%h, expected 13 2 5 1 05",
               bus.out_reduced, bus.out_comp, bus.out_comp_row, bus.out_comp_valid, bus.out_addr);
    end
    cycle(1'b1, 8'h07, 6'd0, 1'b1, 1'b0, acc);
    #1;
    tests++;
    if ({bus.out_reduced, bus.out_comp, bus.out_comp_valid} !== {5'h03, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL cls_07: got red=%h comp=%h cv=%b, expected 03 0 0",
               bus.out_reduced, bus.out_comp, bus.out_comp_valid);
    end
    cycle(1'b1, 8'hF8, 6'd1, 1'b1, 1'b0, acc);
    #1;
    tests++;
    if ({bus.out_reduced, bus.out_comp, bus.out_comp_valid} !== {5'h0C, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL cls_F8: got red=%h comp=%h cv=%b, expected 0c 0 0",
               bus.out_reduced, bus.out_comp, bus.out_comp_valid);
    end
    cycle(1'b1, 8'h80, 6'd2, 1'b1, 1'b0, acc);
    #1;
    tests++;
    if ({bus.out_reduced, bus.out_comp, bus.out_comp_valid} !== {5'h18, 3'd0, 1'b1}) begin
      fails++;
      $display("FAIL cls_80: got red=%h comp=%h cv=%b, expected 18 0 1",
               bus.out_reduced, bus.out_comp, bus.out_comp_valid);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic acc;
    logic [22:0] snap;
    logic [22:0] now;
    int nb0;
    logic [W-1:0] ws[5] = '{8'h5A, 8'h01, 8'hC3, 8'hFF, 8'h7E};
    nb0 = nbeats;
    cycle(1'b1, 8'hA6, 6'd3, 1'b1, 1'b0, acc);
    #1;
    snap = {bus.out_reduced, bus.out_comp, bus.out_comp_row, bus.out_comp_valid,
            bus.out_addr, bus.out_col_last, bus.out_col_comp_cnt};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_weight = 8'h11;
      bus.in_addr = 6'd9;
      bus.out_ready = 1'b0;
      #1;
      now = {bus.out_reduced, bus.out_comp, bus.out_comp_row, bus.out_comp_valid,
             bus.out_addr, bus.out_col_last, bus.out_col_comp_cnt};
      tests++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || now !== snap) begin
        fails++;
        $display("FAIL stall_%0d: got rdy=%b ov=%b f=%h, expected 0 1 %h",
                 i, bus.in_ready, bus.out_valid, now, snap);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, ws[i], A'(10 + i), 1'b1, 1'b0, acc);
      tests++;
      if (acc !== 1'b1) begin
        fails++;
        $display("FAIL resume_%0d: got acc=%b, expected 1", i, acc);
      end
    end
    drain();
    tests++;
    if (nbeats - nb0 != 6) begin
      fails++;
      $display("FAIL bp_count: got %0d beats, expected 6", nbeats - nb0);
    end
  endtask

  task automatic test_column();
    logic acc;
    logic [W-1:0] c1[8] = '{8'h35, 8'h07, 8'h80, 8'h07, 8'h07, 8'h07, 8'h07, 8'h40};
    do_reset();
    do_start();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, c1[i], A'(8 + i), 1'b1, 1'b0, acc);
      #1;
      if (i == 0) begin
        tests++;
        if (bus.out_col_last !== 1'b0 || bus.out_col_comp_cnt !== '0) begin
          fails++;
          $display("FAIL col_row0: got last=%b cnt=%0d, expected 0 0",
                   bus.out_col_last, bus.out_col_comp_cnt);
        end
      end
    end
    tests++;
    if (bus.out_col_last !== 1'b1 || bus.out_col_comp_cnt !== 4'd3) begin
      fails++;
      $display("FAIL col_last: got last=%b cnt=%0d, expected 1 3",
               bus.out_col_last, bus.out_col_comp_cnt);
    end
    for (int i = 0; i < 8; i++)
      cycle(1'b1, (i == 0) ? 8'h80 : 8'h07, A'(16 + i), 1'b1, 1'b0, acc);
    #1;
    tests++;
    if (bus.out_col_last !== 1'b1 || bus.out_col_comp_cnt !== 4'd1) begin
      fails++;
      $display("FAIL col_next: got last=%b cnt=%0d, expected 1 1",
               bus.out_col_last, bus.out_col_comp_cnt);
    end
    drain();
  endtask

  task automatic test_full_frame();
    logic acc;
    logic [W-1:0] w[N];
    int idx, nb0, fd0, exp_nm, cyc;
    bit done;
    do_reset();
    do_start();
    exp_nm = 0;
    for (int i = 0; i < N; i++) begin
      w[i] = W'($urandom);
      if (!is_msr(int'(w[i]))) exp_nm++;
    end
    idx = 0;
    nb0 = nbeats;
    fd0 = fd_cnt;
    done = 0;
    for (cyc = 0; cyc < 3000 && !done; cyc++) begin
      cycle((idx < N) && ($urandom_range(0, 3) != 0), w[idx % N], A'(idx),
            $urandom_range(0, 3) != 0, cyc == 10, acc);
      if (acc) idx++;
      if (nbeats - nb0 == N) done = 1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL frame_timeout: got %0d beats, expected %0d", nbeats - nb0, N);
    end
    #1;
    tests++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || fd_cnt != fd0) begin
      fails++;
      $display("FAIL frame_done: got fd=%b busy=%b early=%0d, expected 1 0 0",
               frame_done, busy, fd_cnt - fd0);
    end
    tests++;
    if (comp_total !== CTW'(exp_nm) || idx != N) begin
      fails++;
      $display("FAIL comp_total: got %0d (in=%0d), expected %0d (in=%0d)",
               comp_total, idx, exp_nm, N);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    #1;
    tests++;
    if (frame_done !== 1'b0 || fd_cnt != fd0 + 1 || comp_total !== CTW'(exp_nm)) begin
      fails++;
      $display("FAIL done_pulse: got fd=%b pulses=%0d ct=%0d, expected 0 1 %0d",
               frame_done, fd_cnt - fd0, comp_total, exp_nm);
    end
  endtask

  task automatic test_abort();
    logic acc;
    logic [W-1:0] wv;
    logic [45:0] snap;
    int n, fd0, nb0;
    do_reset();
    do_start();
    n = 0;
    for (int i = 0; i < 40 && n < 21; i++) begin
      cycle(1'b1, W'($urandom), A'(n), 1'b1, 1'b0, acc);
      if (acc) n++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    snap = {bus.out_valid, bus.out_reduced, bus.out_comp, bus.out_comp_row,
            bus.out_comp_valid, bus.out_addr, bus.out_col_last,
            bus.out_col_comp_cnt, comp_total, busy, frame_done, bus.in_ready};
    tests++;
    if (snap !== '0 || n != 21) begin
      fails++;
      $display("FAIL abort_reset: got %h n=%0d, expected 0 n=21", snap, n);
    end
    q.delete();
    m_col = 0;
    m_total = 0;
    fd0 = fd_cnt;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    tests++;
    if (fd_cnt != fd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got pulses=%0d busy=%b, expected 0 0", fd_cnt - fd0, busy);
    end
    do_start();
    tests++;
    if (comp_total !== '0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart: got ct=%0d busy=%b, expected 0 1", comp_total, busy);
    end
    nb0 = nbeats;
    n = 0;
    for (int i = 0; i < N + 5 && nbeats - nb0 < N; i++) begin
      wv = W'($urandom);
      cycle(n < N, wv, A'(n), 1'b1, 1'b0, acc);
      if (acc) n++;
    end
    #1;
    tests++;
    if (nbeats - nb0 != N || frame_done !== 1'b1 || comp_total !== CTW'(m_total)) begin
      fails++;
      $display("FAIL clean_frame: got beats=%0d fd=%b ct=%0d, expected %0d 1 %0d",
               nbeats - nb0, frame_done, comp_total, N, m_total);
    end
  endtask

  initial begin
    test_reset();
    test_classify();
    test_backpressure();
    test_column();
    test_full_frame();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wpu_stream.md
Name: wpu_stream

Overview:
- Parametrised weight preprocessing unit for a ROWS x COLS systolic array, with a valid/ready stream on both sides.
- Each accepted weight is split into a reduced weight and an optional compensation term: MSR weights are sign-compressed; non-MSR weights keep their upper half and emit a compensation.
- Tracks per-column and per-frame compensation counts.
- Sits between the weight loader and the weight/compensation memories.
- Frames are started explicitly, and completion is signalled by a pulse.

Parameters:
- WEIGHT_W, 8, input weight width; even, >= 4. H = WEIGHT_W/2 (derived).
- ROWS, 8, systolic array rows; power of 2. RB = clog2(ROWS) (derived).
- COLS, 8, systolic array columns. N = ROWS*COLS, ADDR_W = clog2(N) (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle frame start
- in_valid  in  1  input weight valid
- in_ready  out  1  block accepts input this cycle
- in_weight  in  WEIGHT_W  two's-complement weight
- in_addr  in  ADDR_W  weight memory address; row = in_addr[RB-1:0]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- out_reduced  out  H+1  {flag, H-bit data}
- out_comp  out  H-1  compensation weight
- out_comp_row  out  RB  compensation row
- out_comp_valid  out  1  compensation present on this beat
- out_addr  out  ADDR_W  registered in_addr
- out_col_last  out  1  beat carries row ROWS-1
- out_col_comp_cnt  out  clog2(ROWS+1)  compensations in the column ending on this beat; valid only with out_col_last, else 0
- comp_total  out  clog2(N+1)  compensations in the current/last frame
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: every output 0, state IDLE, all counters 0. Reset mid-frame aborts the frame; the pending output is discarded and no frame_done is issued.
- States:
  - IDLE -> LOAD on start. Entering LOAD clears in_cnt, out_cnt, col_cnt and comp_total.
  - LOAD -> DRAIN when the N-th input is accepted.
  - DRAIN -> IDLE when the N-th output handshake completes. frame_done pulses in the cycle after that handshake, coinciding with IDLE.
  - start is ignored outside IDLE.
- Handshakes:
  - in_ready = (state==LOAD) && (!out_valid || out_ready). It is low in IDLE and DRAIN.
  - An input is accepted when in_valid && in_ready.
  - There is one output register; latency is exactly 1 cycle from acceptance to out_valid.
  - out_valid is set on accept. It is cleared on an output handshake with no simultaneous accept. A simultaneous accept and handshake keeps out_valid=1 with the new beat.
  - While out_valid && !out_ready, all out_* fields hold stable.
- Classification: MSR when in_weight[WEIGHT_W-1:H] is all 0s or all 1s.
  - MSR case: out_reduced = {1'b0, in_weight[H:1]}, out_comp = 0, out_comp_row = 0, out_comp_valid = 0.
  - Non-MSR case: out_reduced = {1'b1, in_weight[WEIGHT_W-1:H]}, out_comp = in_weight[H-1:1], out_comp_row = in_addr[RB-1:0], out_comp_valid = 1.
- Bit 0 of the weight is always dropped.
- Column tracking, on accept:
  - If in_addr[RB-1:0] == ROWS-1: out_col_last = 1, out_col_comp_cnt = col_cnt + nonMSR, and col_cnt resets to 0.
  - Otherwise: col_cnt += nonMSR and out_col_last = 0.
  - Column boundaries come from the address, not from in_cnt.
- comp_total increments on each accepted non-MSR weight and holds after the frame until the next start. It cannot exceed N.
- Counters wrap is impossible by construction: in_cnt and out_cnt stop at N.

Test Plan:
- Reset then start, then 0x35 at addr 5 with out_ready=1 -> next cycle out_reduced=0x13, out_comp=2, out_comp_row=5, out_comp_valid=1, out_addr=5.
- 0x07 at addr 0 and 0xF8 at addr 1 -> out_reduced 0x03 then 0x0C, out_comp_valid=0, out_comp=0 for both. 0x80 -> out_reduced=0x18, out_comp=0, out_comp_valid=1.
- Backpressure: hold out_ready=0 for 3 cycles after the first beat -> in_ready=0, out_* stable. Release -> one beat per cycle resumes with no loss or duplication.
- Column with rows 0..7 = {0x35,0x07,0x80,0x07,0x07,0x07,0x07,0x40} -> the row-7 beat has out_col_last=1 and out_col_comp_cnt=3; the next column starts from 0.
- Full 64-weight frame with random in_valid/out_ready -> exactly 64 output beats, frame_done=1 for one cycle after the last handshake, busy falls, comp_total equals the count of non-MSR weights. start pulsed during LOAD has no effect.
- Assert rst during beat 20 -> all outputs 0 and IDLE. A new start produces a clean frame with comp_total restarting at 0.
